dmem_access_ctrl: RTL

Sequencer between the RV32I memory stage and the single-port, word-wide synchronous data RAM (1-cycle read latency, no byte enables). Issues RAM read/write cycles for LB/LH/LW/LBU/LHU/SB/SH/SW. Performs read-modify-write for sub-word stores and aligns and extends load data. Raises a stall so the pipeline holds the request while a multi-cycle access is in flight.

---
 rtl/dmem_access_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory sequencer: RV32I loads/stores to a word-wide 1-cycle-latency RAM, RMW for sub-word stores.
// Optional DMEM_BYTE_WE_EN: RAM with byte write enables, sub-word stores complete in one cycle.
module dmem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_rvalid,
  output logic              o_fault,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_di,
`ifdef DMEM_BYTE_WE_EN
  output logic [3:0]        o_ram_be,
`endif
  input  logic [31:0]       i_ram_dout
);

  typedef enum logic [1:0] {IDLE, LD_CAP, RMW_WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        was_ld;
  logic        f3_legal, misalign, bad_req, is_word_st;
  logic [31:0] ld_shift, ld_val, merged;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^i_addr[31:ADDR_W+2];

  always_comb begin
    if (i_we) f3_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
    else      f3_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                         (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
  end

  assign misalign   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign bad_req    = !f3_legal || misalign;
  assign is_word_st = (i_funct3[1:0] == 2'b10);

  // Load lane extraction: shift the addressed lane down to bit 0, then extend.
  assign ld_shift = i_ram_dout >> {i_addr[1:0], 3'b000};
  always_comb begin
    case (i_funct3)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_val = {24'h0, ld_shift[7:0]};
      3'b101:  ld_val = {16'h0, ld_shift[15:0]};
      default: ld_val = i_ram_dout;
    endcase
  end

  always_comb begin
    merged = i_ram_dout;
    if (i_funct3[1:0] == 2'b00)      merged[{i_addr[1:0], 3'b000} +: 8]  = i_wdata[7:0];
    else if (i_funct3[1:0] == 2'b01) merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_rdata <= 32'h0;
      was_ld  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LD_CAP) begin
        o_rdata <= ld_val;
        was_ld  <= 1'b1;
      end else if (state == RMW_WR) begin
        was_ld  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req && !bad_req) begin
          if (!i_we) state_nxt = LD_CAP;
`ifndef DMEM_BYTE_WE_EN
          else if (!is_word_st) state_nxt = RMW_WR;
`endif
        end
      end
      LD_CAP:  state_nxt = DONE;
      RMW_WR:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by reset so an in-flight RMW write drops the instant reset asserts.
  always_comb begin
    o_stall    = 1'b0;
    o_rvalid   = 1'b0;
    o_fault    = 1'b0;
    o_ram_en   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_addr = i_addr[ADDR_W+1:2];
    o_ram_di   = i_wdata;
`ifdef DMEM_BYTE_WE_EN
    o_ram_be   = 4'b0000;
`endif
    case (state)
      IDLE: begin
        if (i_req) begin
          if (bad_req) begin
            o_fault = 1'b1;
          end else if (i_we) begin
            o_ram_en = 1'b1;
`ifdef DMEM_BYTE_WE_EN
            o_ram_we = 1'b1;
            case (i_funct3[1:0])
              2'b00: begin
                o_ram_di = {4{i_wdata[7:0]}};
                o_ram_be = 4'b0001 << i_addr[1:0];
              end
              2'b01: begin
                o_ram_di = {2{i_wdata[15:0]}};
                o_ram_be = 4'b0011 << {i_addr[1], 1'b0};
              end
              default: o_ram_be = 4'b1111;
            endcase
`else
            o_ram_we = is_word_st;
            o_stall  = !is_word_st;
`endif
          end else begin
            o_ram_en = 1'b1;
            o_stall  = 1'b1;
          end
        end
      end
      LD_CAP: o_stall = 1'b1;
      RMW_WR: begin
        o_ram_en = 1'b1;
        o_ram_we = 1'b1;
        o_ram_di = merged;
        o_stall  = 1'b1;
      end
      default: o_rvalid = was_ld;
    endcase
    if (!i_rst_n) begin
      o_stall  = 1'b0;
      o_rvalid = 1'b0;
      o_fault  = 1'b0;
      o_ram_en = 1'b0;
      o_ram_we = 1'b0;
    end
  end

endmodule
